// File: rtl/motion_key_ctrl.sv
// motion_key_ctrl: W/A/S/D keycode scanner issuing one-cycle move Loads with typematic repeat
// Ports: Clk, Reset (sync, active-high); keycodes = NUM_KEYS packed 8-bit HID slots;
// tick = frame strobe for repeat timing; motionFlag = direction of last Load;
// Load = one-cycle move pulse; Active = a direction key is held and tracked.
module motion_key_ctrl #(
  parameter int NUM_KEYS = 6,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE = 4,
  parameter logic [7:0] KEY_W = 8'h1A,
  parameter logic [7:0] KEY_A = 8'h04,
  parameter logic [7:0] KEY_S = 8'h16,
  parameter logic [7:0] KEY_D = 8'h07
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [8*NUM_KEYS-1:0] keycodes,
  input  logic                  tick,
  output logic [1:0]            motionFlag,
  output logic                  Load,
  output logic                  Active
);
  localparam int MX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t state, state_n;
  logic [3:0] pressed, pressed_q, rise;
  logic [1:0] cur_dir, dir_n;
  logic [CW-1:0] cnt, cnt_n, last;
  logic load_n;
  // W > A > S > D when several candidates are present
  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  always_comb begin
    pressed = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      pressed[0] |= keycodes[8*i+:8] == KEY_W;
      pressed[1] |= keycodes[8*i+:8] == KEY_A;
      pressed[2] |= keycodes[8*i+:8] == KEY_S;
      pressed[3] |= keycodes[8*i+:8] == KEY_D;
    end
  end
  assign rise = pressed & ~pressed_q;
  assign last = state == DELAY ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1);
  assign Active = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dir_n = cur_dir;
    load_n = 1'b0;
    if (rise != '0) begin
      dir_n = lowest(rise);
      load_n = 1'b1;
      cnt_n = '0;
      state_n = DELAY;
    end else if (pressed != '0 && !pressed[cur_dir]) begin
      // current direction released while another is still held: fall back
      dir_n = lowest(pressed);
      load_n = 1'b1;
      cnt_n = '0;
      state_n = DELAY;
    end else if (pressed == '0) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (tick && state != IDLE) begin
      if (cnt == last) begin
        load_n = 1'b1;
        cnt_n = '0;
        state_n = REPEAT;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      cur_dir <= 2'b00;
      pressed_q <= '0;
      Load <= 1'b0;
      motionFlag <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_dir <= dir_n;
      pressed_q <= pressed;
      Load <= load_n;
      if (load_n) motionFlag <= dir_n;
    end
  end
endmodule

// File: tb/tb_motion_key_ctrl.sv
// tb_motion_key_ctrl: randomized and directed checks of motion_key_ctrl against a tick-counting reference model
module tb_motion_key_ctrl;
  localparam int N = 6;
  localparam int RD = 5;
  localparam int RR = 3;
  logic Clk = 0;
  logic Reset = 1;
  logic tick = 0;
  logic [8*N-1:0] keycodes = '0;
  logic [1:0] motionFlag;
  logic Load, Active;
  int total = 0;
  int bad = 0;
  logic [7:0] keys [4] = '{8'h1A, 8'h04, 8'h16, 8'h07};
  logic [7:0] pool [7] = '{8'h00, 8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h05};
  logic [3:0] m_prev;
  int m_dir, m_t;
  bit m_active, m_load;
  logic [1:0] m_flag;
  motion_key_ctrl #(.NUM_KEYS(N), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .Clk(Clk), .Reset(Reset), .keycodes(keycodes), .tick(tick),
    .motionFlag(motionFlag), .Load(Load), .Active(Active)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [3:0] decode(input logic [8*N-1:0] kc);
    logic [3:0] d = '0;
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < N; s++)
        if (kc[8*s+:8] == keys[k]) d[k] = 1'b1;
    return d;
  endfunction
  function automatic int first_set(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction
  function automatic logic [8*N-1:0] slot(input int s, input logic [7:0] code, input logic [8*N-1:0] base);
    logic [8*N-1:0] v = base;
    v[8*s+:8] = code;
    return v;
  endfunction
  // Model: m_t counts ticks seen since the last (re)press; Loads fall on tick RD, RD+RR, RD+2RR, ...
  task automatic model_step();
    logic [3:0] p, r;
    m_load = 0;
    if (Reset) begin
      m_prev = '0; m_dir = 0; m_t = 0; m_active = 0; m_flag = 2'b00;
      return;
    end
    p = decode(keycodes);
    r = p & ~m_prev;
    if (r != 0) begin
      m_dir = first_set(r); m_load = 1; m_t = 0; m_active = 1;
    end else if (p != 0 && !p[m_dir]) begin
      m_dir = first_set(p); m_load = 1; m_t = 0; m_active = 1;
    end else if (p == 0) begin
      m_active = 0; m_t = 0;
    end else if (tick) begin
      m_t++;
      if (m_t == RD || (m_t > RD && (m_t - RD) % RR == 0)) m_load = 1;
    end
    if (m_load) m_flag = 2'(m_dir);
    m_prev = p;
  endtask
  task automatic step(input bit rst, input logic [8*N-1:0] kc, input bit tk);
    Reset = rst;
    keycodes = kc;
    tick = tk;
    model_step();
    @(negedge Clk);
    check("load", 8'(Load), 8'(m_load));
    check("flag", 8'(motionFlag), 8'(m_flag));
    check("active", 8'(Active), 8'(m_active));
  endtask
  initial begin
    logic [8*N-1:0] kc;
    @(negedge Clk);
    repeat (2) step(1, '0, 0);
    check("reset_flag", 8'(motionFlag), 8'h00);
    check("reset_load", 8'(Load), 8'h00);
    check("reset_active", 8'(Active), 8'h00);
    repeat (3) step(0, '0, 0);
    repeat (3) step(0, slot(0, 8'h04, '0), 0);
    repeat (3) step(0, '0, 0);
    for (int c = 0; c < 80; c++) step(0, slot(2, 8'h07, '0), c % 4 == 3);
    step(0, '0, 0);
    kc = slot(0, 8'h1A, '0);
    for (int c = 0; c < 50; c++)
      step(0, (c >= 20 && c < 40) ? slot(1, 8'h16, kc) : kc, c % 3 == 0);
    step(0, '0, 0);
    step(0, slot(1, 8'h04, slot(0, 8'h07, '0)), 0);
    repeat (3) step(0, slot(1, 8'h04, slot(0, 8'h07, '0)), 1);
    step(0, '0, 0);
    kc = slot(0, 8'h1A, '0);
    step(0, kc, 0);
    repeat (RD - 1) step(0, kc, 1);
    step(0, slot(3, 8'h04, kc), 1);
    repeat (3) step(0, slot(3, 8'h04, kc), 0);
    kc = slot(4, 8'h16, '0);
    repeat (4) step(0, kc, 0);
    repeat (2) step(1, kc, 0);
    repeat (4) step(0, kc, 1);
    kc = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) kc = slot($urandom_range(N - 1), pool[$urandom_range(6)], kc);
      if ($urandom_range(40) == 0) kc = '0;
      step($urandom_range(300) == 0, kc, $urandom_range(2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
